// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - state_t      : sequencer states (IDLE -> ACCESS -> RESP, or IDLE -> RESP on error)
//   - NUM_PORTS    : number of requesters
//   - MEM_WORDS    : depth of the data memory behind the arbiter
//   - ARB_*        : default widths used by dmem_arbiter
//   - addr_is_bad(): flags misaligned or out-of-range byte addresses
package dmem_arb_pkg;

  localparam int NUM_PORTS   = 2;
  localparam int MEM_WORDS   = 256;

  localparam int ARB_ADDR_W  = 32;
  localparam int ARB_DATA_W  = 32;
  localparam int ARB_IDX_LSB = 2;
  localparam int ARB_IDX_W   = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // An address is rejected when it is not word aligned or when it points
  // beyond the last memory word.
  function automatic logic addr_is_bad(input logic [ARB_ADDR_W-1:0] addr);
    return (addr[ARB_IDX_LSB-1:0] != '0) ||
           (addr[ARB_ADDR_W-1:ARB_IDX_LSB+ARB_IDX_W] != '0);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
//   req[1:0] : pending requests
//   last     : id of the port served most recently (flop lives in the parent)
//   gnt[1:0] : one-hot grant, all-zero when nobody requests
//   gnt_id   : index of the granted port (0 when nobody requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    gnt    = 2'b00;
    gnt_id = 1'b0;
    unique case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last;   // contention: the port not served last wins
      default: gnt_id = 1'b0;
    endcase
    if (req != 2'b00) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-port
// 256x32 data memory. Port 0 is the core load/store path, port 1 a secondary
// master. Each accepted request produces exactly one memory strobe cycle and
// one registered done pulse (with err for rejected addresses).
//   clk, rst_n                     : clock, asynchronous active-low reset
//   req/we/addr/wdata{0,1}         : requester inputs, held until done
//   done/err/rdata{0,1}            : registered response, valid while done=1
//   mem_addr/mem_write_data        : memory address and write data
//   mem_write/mem_read             : memory strobes, high only in ACCESS
//   mem_read_data                  : combinational memory read data
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int IDX_LSB = ARB_IDX_LSB,
  parameter int IDX_W   = ARB_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  output logic              done1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t               state_q, state_d;
  logic                 last_q;      // port served most recently; 1 => port 0 preferred
  logic                 id_q;
  logic                 we_q;
  logic [IDX_W-1:0]     idx_q;       // only the word index survives a good request
  logic [DATA_W-1:0]    wdata_q;
  logic [NUM_PORTS-1:0] done_q;
  logic [NUM_PORTS-1:0] err_q;
  logic [DATA_W-1:0]    rdata_q [NUM_PORTS];

  logic [1:0]           gnt;
  logic                 gnt_id;
  logic                 we_sel;
  logic [ADDR_W-1:0]    addr_sel;
  logic [DATA_W-1:0]    wdata_sel;
  logic                 bad_sel;

  rr_arb2 u_rr_arb2 (
    .req    ({req1, req0}),
    .last   (last_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Winner's request fields; only meaningful while some grant is active.
  assign we_sel    = gnt[1] ? we1    : we0;
  assign addr_sel  = gnt[1] ? addr1  : addr0;
  assign wdata_sel = gnt[1] ? wdata1 : wdata0;
  assign bad_sel   = addr_is_bad(addr_sel);

  // Next state and memory strobes. Strobes come straight from the state so an
  // asynchronous reset during ACCESS removes them without waiting for a clock.
  always_comb begin
    state_d        = state_q;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          state_d = bad_sel ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        state_d                              = RESP;
        mem_addr[IDX_LSB+IDX_W-1:IDX_LSB]    = idx_q;
        mem_write_data                       = wdata_q;
        mem_write                            = we_q;
        mem_read                             = ~we_q;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      // NOTE: the response words are two plain registers, not a RAM array,
      // so they are reset like any other flop to give rdata a defined 0.
      for (int p = 0; p < NUM_PORTS; p++) begin
        rdata_q[p] <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= '0;
      err_q   <= '0;
      unique case (state_q)
        IDLE: begin
          if (gnt != 2'b00) begin
            last_q  <= gnt_id;
            id_q    <= gnt_id;
            we_q    <= we_sel;
            idx_q   <= addr_sel[IDX_LSB+IDX_W-1:IDX_LSB];
            wdata_q <= wdata_sel;
            // Rejected requests skip ACCESS and respond on the next cycle.
            if (bad_sel) begin
              done_q[gnt_id]  <= 1'b1;
              err_q[gnt_id]   <= 1'b1;
              rdata_q[gnt_id] <= '0;
            end
          end
        end
        ACCESS: begin
          done_q[id_q]  <= 1'b1;
          rdata_q[id_q] <= we_q ? '0 : mem_read_data;
        end
        default: ;
      endcase
    end
  end

  assign done0  = done_q[0];
  assign done1  = done_q[1];
  assign err0   = err_q[0];
  assign err1   = err_q[1];
  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];

endmodule
